// File: rtl/div_with_sub_shift.sv
// div_with_sub_shift
//   Sequential restoring divider, one quotient bit per clock. Divides a
//   2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor and returns a
//   2*WIDTH-bit quotient plus a WIDTH-bit remainder.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      request, only looked at in IDLE
//   dividend   2*WIDTH-bit dividend, captured when start is accepted
//   divisor    WIDTH-bit divisor, captured when start is accepted
//   quotient   registered quotient, changes only on completion or reset
//   remainder  registered remainder, changes only on completion or reset
//   busy       high while iterations are in flight
//   done       one-cycle pulse, results valid while high
//   div_zero   flags a divide-by-zero result, held until the next completion
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one shift/subtract iteration per clock, 2*WIDTH in total
// DONE  | single cycle with done high, then back to IDLE

module div_with_sub_shift #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [QW-1:0]     quo_w_q, quo_w_d;
  logic [WIDTH:0]    rem_w_q, rem_w_d;
  logic [WIDTH-1:0]  dvs_w_q, dvs_w_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QW-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_zero_q, div_zero_d;

  // Datapath for one iteration of the restoring algorithm.
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH+1:0]  trial;
  logic              borrow;
  logic [WIDTH:0]    rem_next;
  logic [QW-1:0]     quo_next;

  // The partial remainder always stays below the divisor, so its top bit is
  // never set before a shift and drops out of the shifted value.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_w_q[WIDTH];

  always_comb begin
    rem_shift = {rem_w_q[WIDTH-1:0], quo_w_q[QW-1]};
    trial     = {1'b0, rem_shift} - {2'b00, dvs_w_q};
    borrow    = trial[WIDTH+1];
    // On borrow the shifted remainder is kept as-is (the restore step).
    rem_next  = borrow ? rem_shift : trial[WIDTH:0];
    quo_next  = {quo_w_q[QW-2:0], ~borrow};
  end

  always_comb begin
    state_d     = state_q;
    quo_w_d     = quo_w_q;
    rem_w_d     = rem_w_q;
    dvs_w_d     = dvs_w_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_w_d = dividend;
          dvs_w_d = divisor;
          rem_w_d = '0;
          cnt_d   = '0;
          if (divisor == '0) begin
            // No iterations: publish the saturated quotient at once.
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        quo_w_d = quo_next;
        rem_w_d = rem_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Final iteration publishes its own freshly computed result.
          quotient_d  = quo_next;
          remainder_d = rem_next[WIDTH-1:0];
          div_zero_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      quo_w_q     <= '0;
      rem_w_q     <= '0;
      dvs_w_q     <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_w_q     <= quo_w_d;
      rem_w_q     <= rem_w_d;
      dvs_w_q     <= dvs_w_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;

endmodule
